// File: rtl/gpmc_to_wishbone_bridge.sv
// gpmc_to_wishbone_bridge
//
// Purpose: turns AM335x GPMC asynchronous address/data-multiplexed host
// accesses into single Wishbone classic cycles. The GPMC controls and the AD
// bus are treated as asynchronous and resynchronised into the clk domain.
// Read data is driven back onto the shared AD pins while the host selects
// the device with its output enable asserted.
//
// Ports:
//   clk            system clock (at least 4x faster than GPMC strobe widths)
//   reset          synchronous, active-high reset
//   gpmc_ad        multiplexed address/data pins (bidirectional)
//   gpmc_advn      address valid, active low; address taken on rising edge
//   gpmc_csn1      chip select, active low
//   gpmc_wein      write enable, active low
//   gpmc_oen       output enable, active low
//   gpmc_clk       GPMC clock; unused in asynchronous mode
//   wbm_address    Wishbone address
//   wbm_readdata   Wishbone read data
//   wbm_writedata  Wishbone write data
//   wbm_ack        Wishbone acknowledge
//   wbm_cycle      Wishbone cycle
//   wbm_strobe     Wishbone strobe
//   wbm_write      Wishbone write enable
module gpmc_to_wishbone_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [15:0]           gpmc_ad,
  input  logic                  gpmc_advn,
  input  logic                  gpmc_csn1,
  input  logic                  gpmc_wein,
  input  logic                  gpmc_oen,
  input  logic                  gpmc_clk,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic                  wbm_ack,
  output logic                  wbm_cycle,
  output logic                  wbm_strobe,
  output logic                  wbm_write
);

  // Bit positions of the control signals inside the synchroniser vectors.
  localparam int CTL_CSN  = 0;
  localparam int CTL_ADVN = 1;
  localparam int CTL_WEN  = 2;
  localparam int CTL_OEN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  logic [3:0]            w_ctl_pins;
  logic [3:0]            r_ctl_s1;
  logic [3:0]            r_ctl_s2;
  logic [3:0]            r_ctl_s3;
  logic [15:0]           r_ad_s1;
  logic [15:0]           r_ad_s2;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_we;
  logic                  w_cyc_nxt;
  logic                  w_stb_nxt;
  logic                  w_we_nxt;
  logic                  w_load_addr;
  logic                  w_load_wdata;
  logic                  w_load_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_sel;
  logic                  w_advn_rise;
  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_unused;

  assign w_ctl_pins = {gpmc_oen, gpmc_wein, gpmc_advn, gpmc_csn1};

  // Synchronisers: two flops on every input, a third on the controls so
  // edges are detected between s2 and s3 (both already in the clk domain).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctl_s1 <= 4'hF;
      r_ctl_s2 <= 4'hF;
      r_ctl_s3 <= 4'hF;
      r_ad_s1  <= 16'h0000;
      r_ad_s2  <= 16'h0000;
    end else begin
      r_ctl_s1 <= w_ctl_pins;
      r_ctl_s2 <= r_ctl_s1;
      r_ctl_s3 <= r_ctl_s2;
      r_ad_s1  <= gpmc_ad;
      r_ad_s2  <= r_ad_s1;
    end
  end

  assign w_sel       = ~r_ctl_s2[CTL_CSN];
  assign w_advn_rise = r_ctl_s2[CTL_ADVN] & ~r_ctl_s3[CTL_ADVN];
  assign w_wr_req    = w_sel & ~r_ctl_s2[CTL_WEN] & r_ctl_s3[CTL_WEN];
  assign w_rd_req    = w_sel & ~r_ctl_s2[CTL_OEN] & r_ctl_s3[CTL_OEN];

  // Next-state and next-output logic. Requests are honoured only in IDLE so
  // the address and write data stay frozen for the whole Wishbone cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cyc_nxt    = r_cyc;
    w_stb_nxt    = r_stb;
    w_we_nxt     = r_we;
    w_load_addr  = 1'b0;
    w_load_wdata = 1'b0;
    w_load_rdata = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cyc_nxt   = 1'b0;
        w_stb_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_load_addr = w_advn_rise & w_sel;
        if (w_wr_req) begin
          // Write wins when both strobes fall in the same cycle.
          w_state_nxt  = ST_WR;
          w_cyc_nxt    = 1'b1;
          w_stb_nxt    = 1'b1;
          w_we_nxt     = 1'b1;
          w_load_wdata = 1'b1;
        end else if (w_rd_req) begin
          w_state_nxt = ST_RD;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR: begin
        if (wbm_ack) begin
          w_state_nxt = ST_IDLE;
          w_cyc_nxt   = 1'b0;
          w_stb_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
        end else begin
          w_state_nxt = ST_WR;
        end
      end
      ST_RD: begin
        if (wbm_ack) begin
          w_state_nxt  = ST_IDLE;
          w_cyc_nxt    = 1'b0;
          w_stb_nxt    = 1'b0;
          w_we_nxt     = 1'b0;
          w_load_rdata = 1'b1;
        end else begin
          w_state_nxt = ST_RD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cyc_nxt   = 1'b0;
        w_stb_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  // State, registered bus controls and the address/data holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_stb   <= w_stb_nxt;
      r_we    <= w_we_nxt;
      if (w_load_addr) begin
        r_addr <= r_ad_s2[ADDR_WIDTH-1:0];
      end
      if (w_load_wdata) begin
        r_wdata <= r_ad_s2;
      end
      if (w_load_rdata) begin
        r_rdata <= wbm_readdata;
      end
    end
  end

  // The pad driver uses the raw pins so the bus is released as soon as the
  // host deasserts chip select or output enable.
  assign gpmc_ad = (~gpmc_csn1 & ~gpmc_oen) ? r_rdata : {16{1'bz}};

  assign wbm_address   = r_addr;
  assign wbm_writedata = r_wdata;
  assign wbm_cycle     = r_cyc;
  assign wbm_strobe    = r_stb;
  assign wbm_write     = r_we;

  // gpmc_clk has no function in asynchronous mode; upper AD bits are unused
  // when the address is narrower than the bus.
  assign w_unused = &{1'b0, gpmc_clk, r_ad_s2};

endmodule

// File: tb/tb_gpmc_to_wishbone_bridge.sv
// Directed testbench for gpmc_to_wishbone_bridge.
module tb_gpmc_to_wishbone_bridge;

  logic        clk;
  logic        reset;
  wire  [15:0] gpmc_ad;
  logic        gpmc_advn;
  logic        gpmc_csn1;
  logic        gpmc_wein;
  logic        gpmc_oen;
  logic        gpmc_clk;
  logic [15:0] wbm_address;
  logic [15:0] wbm_readdata;
  logic [15:0] wbm_writedata;
  logic        wbm_ack;
  logic        wbm_cycle;
  logic        wbm_strobe;
  logic        wbm_write;

  logic        host_drive;
  logic [15:0] host_ad;

  int checks = 0;
  int errors = 0;

  assign gpmc_ad = host_drive ? host_ad : 16'hzzzz;

  gpmc_to_wishbone_bridge #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .gpmc_ad      (gpmc_ad),
    .gpmc_advn    (gpmc_advn),
    .gpmc_csn1    (gpmc_csn1),
    .gpmc_wein    (gpmc_wein),
    .gpmc_oen     (gpmc_oen),
    .gpmc_clk     (gpmc_clk),
    .wbm_address  (wbm_address),
    .wbm_readdata (wbm_readdata),
    .wbm_writedata(wbm_writedata),
    .wbm_ack      (wbm_ack),
    .wbm_cycle    (wbm_cycle),
    .wbm_strobe   (wbm_strobe),
    .wbm_write    (wbm_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int hi_cnt;
    int seen_cyc;

    reset        = 1'b1;
    gpmc_advn    = 1'b1;
    gpmc_csn1    = 1'b1;
    gpmc_wein    = 1'b1;
    gpmc_oen     = 1'b1;
    gpmc_clk     = 1'b0;
    wbm_readdata = 16'h0000;
    wbm_ack      = 1'b0;
    host_drive   = 1'b1;
    host_ad      = 16'h0000;

    // Reset held
    step(3);
    check("rst_cyc",   {15'd0, wbm_cycle},  16'h0000);
    check("rst_stb",   {15'd0, wbm_strobe}, 16'h0000);
    check("rst_we",    {15'd0, wbm_write},  16'h0000);
    check("rst_addr",  wbm_address,         16'h0000);
    check("rst_wdata", wbm_writedata,       16'h0000);
    reset = 1'b0;
    step(1);

    // Write: address FFFF, data DEAD, ack after one busy cycle
    gpmc_csn1 = 1'b0;
    gpmc_advn = 1'b0;
    host_ad   = 16'hFFFF;
    step(2);
    gpmc_advn = 1'b1;
    step(3);
    check("wr_addr", wbm_address, 16'hFFFF);
    gpmc_wein = 1'b0;
    host_ad   = 16'hDEAD;
    step(2);
    check("wr_cyc_not_yet", {15'd0, wbm_cycle}, 16'h0000);
    step(1);
    check("wr_cyc",   {15'd0, wbm_cycle},  16'h0001);
    check("wr_stb",   {15'd0, wbm_strobe}, 16'h0001);
    check("wr_we",    {15'd0, wbm_write},  16'h0001);
    check("wr_wdata", wbm_writedata,       16'hDEAD);
    step(1);
    check("wr_cyc_hold", {15'd0, wbm_cycle}, 16'h0001);
    wbm_ack   = 1'b1;
    gpmc_wein = 1'b1;
    step(1);
    wbm_ack = 1'b0;
    check("wr_cyc_end", {15'd0, wbm_cycle},  16'h0000);
    check("wr_stb_end", {15'd0, wbm_strobe}, 16'h0000);
    check("wr_we_end",  {15'd0, wbm_write},  16'h0000);

    // Read: address AAAA, data F0F0, ack after 2 clk
    gpmc_advn = 1'b0;
    host_ad   = 16'hAAAA;
    step(2);
    gpmc_advn = 1'b1;
    step(3);
    check("rd_addr", wbm_address, 16'hAAAA);
    host_drive   = 1'b0;
    gpmc_oen     = 1'b0;
    wbm_readdata = 16'hF0F0;
    step(3);
    check("rd_cyc", {15'd0, wbm_cycle},  16'h0001);
    check("rd_stb", {15'd0, wbm_strobe}, 16'h0001);
    check("rd_we",  {15'd0, wbm_write},  16'h0000);
    step(1);
    check("rd_cyc_hold", {15'd0, wbm_cycle}, 16'h0001);
    wbm_ack = 1'b1;
    step(1);
    wbm_ack = 1'b0;
    check("rd_cyc_end", {15'd0, wbm_cycle}, 16'h0000);
    check("rd_pad",     gpmc_ad,            16'hF0F0);
    step(1);
    check("rd_single", {15'd0, wbm_cycle}, 16'h0000);
    check("rd_pad_hold", gpmc_ad, 16'hF0F0);
    // Released pad: only the host value may appear on the bus
    gpmc_oen   = 1'b1;
    host_drive = 1'b1;
    host_ad    = 16'h0F0F;
    #1;
    check("pad_hiz", gpmc_ad, 16'h0F0F);
    step(1);

    // Deselected: no cycles, address unchanged
    gpmc_csn1 = 1'b1;
    step(3);
    seen_cyc = 0;
    gpmc_advn = 1'b0;
    host_ad   = 16'h1234;
    for (int i = 0; i < 12; i++) begin
      if (i == 2)  gpmc_advn = 1'b1;
      if (i == 4)  gpmc_wein = 1'b0;
      if (i == 6)  gpmc_wein = 1'b1;
      if (i == 7)  gpmc_oen  = 1'b0;
      if (i == 9)  gpmc_oen  = 1'b1;
      step(1);
      if (wbm_cycle) seen_cyc++;
    end
    check("desel_no_cyc", seen_cyc[15:0], 16'h0000);
    check("desel_addr",   wbm_address,    16'hAAAA);
    check("desel_pad",    gpmc_ad,        16'h1234);

    // Delayed ack (5 clk) write, second wein edge during busy is dropped
    gpmc_csn1 = 1'b0;
    gpmc_advn = 1'b0;
    host_ad   = 16'h0100;
    step(2);
    gpmc_advn = 1'b1;
    step(3);
    check("dly_addr", wbm_address, 16'h0100);
    gpmc_wein = 1'b0;
    host_ad   = 16'h5A5A;
    step(3);
    check("dly_wdata", wbm_writedata, 16'h5A5A);
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (wbm_cycle && wbm_strobe) hi_cnt++;
      if (i == 0) gpmc_wein = 1'b1;
      if (i == 1) begin
        gpmc_wein = 1'b0;
        host_ad   = 16'hBEEF;
      end
      if (i == 4) wbm_ack = 1'b1;
      step(1);
    end
    wbm_ack = 1'b0;
    check("dly_hold_cnt", hi_cnt[15:0],          16'h0005);
    check("dly_cyc_end",  {15'd0, wbm_cycle},    16'h0000);
    gpmc_wein = 1'b1;
    seen_cyc  = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (wbm_cycle) seen_cyc++;
    end
    check("dly_dropped",     seen_cyc[15:0], 16'h0000);
    check("dly_wdata_keep",  wbm_writedata,  16'h5A5A);

    // Reset asserted in RD before ack
    gpmc_advn = 1'b0;
    host_ad   = 16'h0042;
    step(2);
    gpmc_advn = 1'b1;
    step(3);
    check("rr_addr", wbm_address, 16'h0042);
    host_drive   = 1'b0;
    gpmc_oen     = 1'b0;
    wbm_readdata = 16'h1111;
    step(3);
    check("rr_cyc", {15'd0, wbm_cycle}, 16'h0001);
    reset   = 1'b1;
    wbm_ack = 1'b1;
    step(1);
    check("rr_cyc_rst", {15'd0, wbm_cycle},  16'h0000);
    check("rr_stb_rst", {15'd0, wbm_strobe}, 16'h0000);
    check("rr_addr_rst", wbm_address,        16'h0000);
    check("rr_rdata",   gpmc_ad,             16'h0000);
    wbm_ack  = 1'b0;
    gpmc_oen = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);
    check("rr_idle", {15'd0, wbm_cycle}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
